// File: rtl/sdfa_host_feeder_if.sv
// Host-side streams of sdfa_host_feeder: image words in, label strobe in, voltage samples out.
interface sdfa_host_feeder_if;
  logic [31:0] s_img_data;
  logic        s_img_valid;
  logic        s_img_ready;
  logic [3:0]  s_label;
  logic        s_label_valid;
  logic [13:0] m_volt_data;
  logic        m_volt_valid;
  logic        m_volt_ready;

  modport master (
    output s_img_data, s_img_valid, s_label, s_label_valid, m_volt_ready,
    input  s_img_ready, m_volt_data, m_volt_valid
  );

  modport slave (
    input  s_img_data, s_img_valid, s_label, s_label_valid, m_volt_ready,
    output s_img_ready, m_volt_data, m_volt_valid
  );
endinterface

// File: rtl/sdfa_host_feeder.sv
// Board-side driver for the SDFA chip pads: init sequence, image/label streaming, voltage capture FIFO.
// Define SDFA_FEED_SYNC_EN for a two-flop synchronizer on the chip input pins.
module sdfa_host_feeder #(
  parameter int unsigned WORDS_PER_IMG = 25,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_init,
  input  logic [13:0]        init_data,
  input  logic               mode_train,
  input  logic               mode_infer,
  input  logic               mode_sto_infer,
  sdfa_host_feeder_if.slave  host,
  output logic               volt_overflow,
  output logic               busy,
  input  logic               chip_img_request,
  input  logic               chip_label_request,
  input  logic               chip_output_valid,
  input  logic               chip_init_fin,
  input  logic [13:0]        chip_neuron_voltages,
  output logic [31:0]        chip_image,
  output logic               chip_input_valid,
  output logic               chip_pause,
  output logic [3:0]         chip_label0,
  output logic               chip_initialize,
  output logic [13:0]        chip_init_val,
  output logic               chip_train,
  output logic               chip_infer,
  output logic               chip_sto_infer
);

  localparam int unsigned CW = $clog2(WORDS_PER_IMG + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = 18;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_READY, ST_IMG} state_t;

  // Chip pin sampling: {img_request, label_request, output_valid, init_fin, voltages}
  logic [SW-1:0] pins, samp;
  assign pins = {chip_img_request, chip_label_request, chip_output_valid, chip_init_fin,
                 chip_neuron_voltages};

`ifdef SDFA_FEED_SYNC_EN
  logic [SW-1:0] meta;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      samp <= '0;
    end else begin
      meta <= pins;
      samp <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) samp <= '0;
    else         samp <= pins;
  end
`endif

  logic       img_prev, label_prev, fin_prev;
  logic       img_edge, label_edge, fin_edge, samp_ov;
  logic [13:0] samp_volt;
  assign img_edge   = samp[17] & ~img_prev;
  assign label_edge = samp[16] & ~label_prev;
  assign samp_ov    = samp[15];
  assign fin_edge   = samp[14] & ~fin_prev;
  assign samp_volt  = samp[13:0];

  state_t         state;
  logic [CW-1:0]  word_cnt;
  logic           enter_init, xfer, last_word;
  assign enter_init = cmd_init && (state != ST_INIT);
  assign xfer       = (state == ST_IMG) && host.s_img_valid && host.s_img_ready;
  assign last_word  = (word_cnt == CW'(WORDS_PER_IMG - 1));

  // Label latch / pending / wait-for-label next values
  logic [3:0] label_latch, latch_nxt, label_val;
  logic       label_pending, pending_nxt, label_wait, wait_nxt, label_upd;

  always_comb begin
    label_upd   = 1'b0;
    label_val   = label_latch;
    latch_nxt   = label_latch;
    pending_nxt = label_pending;
    wait_nxt    = label_wait;
    if (label_wait) begin
      if (host.s_label_valid) begin
        label_upd = 1'b1;
        label_val = host.s_label;
        wait_nxt  = 1'b0;
      end
    end else if (label_edge) begin
      if (label_pending) begin
        label_upd   = 1'b1;
        pending_nxt = host.s_label_valid;
        if (host.s_label_valid) latch_nxt = host.s_label;
      end else if (host.s_label_valid) begin
        label_upd = 1'b1;
        label_val = host.s_label;
      end else begin
        wait_nxt = 1'b1;
      end
    end else if (host.s_label_valid) begin
      latch_nxt   = host.s_label;
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      img_prev         <= 1'b0;
      label_prev       <= 1'b0;
      fin_prev         <= 1'b0;
      label_latch      <= '0;
      label_pending    <= 1'b0;
      label_wait       <= 1'b0;
      host.s_img_ready <= 1'b0;
      busy             <= 1'b0;
      chip_image       <= '0;
      chip_input_valid <= 1'b0;
      chip_pause       <= 1'b0;
      chip_label0      <= '0;
      chip_initialize  <= 1'b0;
      chip_init_val    <= '0;
      chip_train       <= 1'b0;
      chip_infer       <= 1'b0;
      chip_sto_infer   <= 1'b0;
    end else begin
      img_prev         <= samp[17];
      label_prev       <= samp[16];
      fin_prev         <= samp[14];
      chip_train       <= mode_train;
      chip_infer       <= mode_infer;
      chip_sto_infer   <= mode_sto_infer;
      chip_input_valid <= xfer;
      if (xfer) chip_image <= host.s_img_data;
      chip_pause       <= ((state == ST_IMG) && !xfer) || wait_nxt;
      label_latch      <= latch_nxt;
      label_pending    <= pending_nxt;
      label_wait       <= wait_nxt;
      if (label_upd) chip_label0 <= label_val;

      if (enter_init) begin
        state            <= ST_INIT;
        chip_initialize  <= 1'b1;
        chip_init_val    <= init_data;
        busy             <= 1'b1;
        host.s_img_ready <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            chip_init_val <= init_data;
            if (fin_edge) begin
              state           <= ST_READY;
              chip_initialize <= 1'b0;
              busy            <= 1'b0;
            end
          end
          ST_READY: if (img_edge) begin
            state            <= ST_IMG;
            word_cnt         <= '0;
            host.s_img_ready <= 1'b1;
            busy             <= 1'b1;
          end
          ST_IMG: if (xfer) begin
            word_cnt <= word_cnt + CW'(1);
            if (last_word) begin
              state            <= ST_READY;
              host.s_img_ready <= 1'b0;
              busy             <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Voltage capture FIFO; a pop while full frees the slot for a same-cycle push
  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          full, push, pop;
  assign full = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
  assign pop  = host.m_volt_valid && host.m_volt_ready;
  assign push = samp_ov && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !enter_init) mem[wr_ptr] <= samp_volt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      volt_overflow <= 1'b0;
    end else if (enter_init) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      volt_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW + 1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW + 1)'(1);
      if (samp_ov && full && !pop) volt_overflow <= 1'b1;
    end
  end

  assign host.m_volt_valid = (fifo_cnt != '0);
  assign host.m_volt_data  = host.m_volt_valid ? mem[rd_ptr] : '0;

endmodule
